// File: rtl/rs_issue_select_pkg.sv
// Shared types for the issue stage: packets, operand-source flags, FU channels.
package rs_issue_select_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned CH_W  = 2;

    typedef enum logic [1:0] {
        TAGTAG = 2'd0,
        TAGCDB = 2'd1,
        CDBTAG = 2'd2,
        CDBCDB = 2'd3
    } flag_e;

    // Channel index doubles as the FU channel number.
    typedef enum logic [CH_W-1:0] {
        ALU  = 2'd0,
        MULT = 2'd1,
        MEM  = 2'd2
    } channel_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Channel kept as raw bits so an out-of-range code can be carried (and never picked).
    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] channel;
        logic            is_ZEROREG;
        logic [OP_W-1:0] opcode;
        logic [XLEN-1:0] rs1_value;
        logic [XLEN-1:0] rs2_value;
    } is_packet_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  reg_value;
    } cdb_packet_t;

    localparam is_packet_t NOP_PACKET = '{
        valid:      1'b0,
        channel:    2'd0,
        is_ZEROREG: 1'b1,
        opcode:     '0,
        rs1_value:  '0,
        rs2_value:  '0
    };

    // Substitute the current broadcast value for operands still waiting on the CDB.
    function automatic is_packet_t forward_operands(input is_packet_t pkt,
                                                    input flag_e flag,
                                                    input logic [XLEN-1:0] cdb_value);
        is_packet_t p;
        p = pkt;
        unique case (flag)
            TAGCDB:  p.rs2_value = cdb_value;
            CDBTAG:  p.rs1_value = cdb_value;
            CDBCDB: begin
                p.rs1_value = cdb_value;
                p.rs2_value = cdb_value;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rs_issue_select_rr_picker.sv
// Round-robin picker: lowest requester at or above ptr, wrapping, via double-width masking.
module rs_issue_select_rr_picker #(
    parameter  int unsigned N  = 8,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o,
    output logic          any_grant_o
);

    localparam int unsigned W2    = 2 * N;
    localparam int unsigned POS_W = $clog2(W2);

    logic [N-1:0]     hi_mask;
    logic [W2-1:0]    dbl_req;
    logic [POS_W-1:0] pos;

    // Lower half keeps requests at/above ptr; upper half is the full vector for wrap-around.
    always_comb begin
        hi_mask = {N{1'b1}} << ptr_i;
        dbl_req = {req_i, req_i & hi_mask};
        pos     = '0;
        for (int i = W2 - 1; i >= 0; i--) begin
            if (dbl_req[i]) begin
                pos = POS_W'(i);
            end
        end
        if (pos >= POS_W'(N)) begin
            grant_idx_o = PW'(pos - POS_W'(N));
        end else begin
            grant_idx_o = PW'(pos);
        end
        any_grant_o = |req_i;
        grant_o     = any_grant_o ? (N'(1) << grant_idx_o) : '0;
    end

endmodule

// File: rtl/rs_issue_select.sv
// Issue stage: per-channel round-robin pick from the RS, CDB forwarding, held issue registers.
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter  int unsigned RS_SIZE = 8,
    parameter  int unsigned NUM_CH  = 3,
    localparam int unsigned PTR_W   = $clog2(RS_SIZE)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic [RS_SIZE-1:0]  entry_ready,
    input  flag_e               entry_flag   [RS_SIZE],
    input  is_packet_t          entry_packet [RS_SIZE],
    input  cdb_packet_t         cdb_packet_in,
    input  logic [NUM_CH-1:0]   fu_ready,
    output logic [RS_SIZE-1:0]  entry_clear,
    output logic [NUM_CH-1:0]   issue_valid,
    output is_packet_t          issue_packet [NUM_CH]
);

    logic [RS_SIZE-1:0] req       [NUM_CH];
    logic [RS_SIZE-1:0] grant_oh  [NUM_CH];
    logic [PTR_W-1:0]   grant_idx [NUM_CH];
    logic [NUM_CH-1:0]  any_grant;
    logic [NUM_CH-1:0]  slot_free;
    logic [NUM_CH-1:0]  win;

    slot_state_e        state_q   [NUM_CH];
    slot_state_e        state_d   [NUM_CH];
    is_packet_t         pkt_q     [NUM_CH];
    is_packet_t         pkt_d     [NUM_CH];
    logic [PTR_W-1:0]   rr_ptr_q  [NUM_CH];
    logic [PTR_W-1:0]   rr_ptr_d  [NUM_CH];

    logic unused_cdb;
    assign unused_cdb = ^{cdb_packet_in.valid, cdb_packet_in.tag};

    // Candidate set per channel: ready entries steered to that channel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            req[c] = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                req[c][i] = entry_ready[i] && (entry_packet[i].channel == CH_W'(c));
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pick
        rs_issue_select_rr_picker #(.N(RS_SIZE)) u_pick (
            .req_i       (req[g]),
            .ptr_i       (rr_ptr_q[g]),
            .grant_o     (grant_oh[g]),
            .grant_idx_o (grant_idx[g]),
            .any_grant_o (any_grant[g])
        );
    end

    // Per-channel EMPTY/FULL next state, winner clear, packet load and pointer advance.
    always_comb begin
        state_d     = state_q;
        pkt_d       = pkt_q;
        rr_ptr_d    = rr_ptr_q;
        entry_clear = '0;
        slot_free   = '0;
        win         = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            slot_free[c] = (state_q[c] == EMPTY) || fu_ready[c];
            win[c]       = any_grant[c] && slot_free[c] && !squash && !reset;
            if (win[c]) begin
                entry_clear = entry_clear | grant_oh[c];
                state_d[c]  = FULL;
                pkt_d[c]    = forward_operands(entry_packet[grant_idx[c]],
                                               entry_flag[grant_idx[c]],
                                               cdb_packet_in.reg_value);
                rr_ptr_d[c] = (grant_idx[c] == PTR_W'(RS_SIZE - 1)) ? '0
                                                                    : grant_idx[c] + PTR_W'(1);
            end else if ((state_q[c] == FULL) && fu_ready[c]) begin
                state_d[c] = EMPTY;
            end
        end
    end

    // Issue registers; squash empties and drops held packets but keeps fairness pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= EMPTY;
                pkt_q[c]    <= NOP_PACKET;
                rr_ptr_q[c] <= '0;
            end
        end else if (squash) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= EMPTY;
                pkt_q[c]    <= NOP_PACKET;
                rr_ptr_q[c] <= rr_ptr_d[c];
            end
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Registered outputs straight from the issue registers.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            issue_valid[c]  = (state_q[c] == FULL);
            issue_packet[c] = pkt_q[c];
        end
    end

endmodule

// File: tb/tb_rs_issue_select.sv
// Scoreboard bench for rs_issue_select: reference model predicts clears and next issue state.
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    localparam int RS = 8;
    localparam int NC = 3;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [7:0]  entry_ready;
    flag_e       entry_flag   [RS];
    is_packet_t  entry_packet [RS];
    cdb_packet_t cdb_packet_in;
    logic [2:0]  fu_ready;
    logic [7:0]  entry_clear;
    logic [2:0]  issue_valid;
    is_packet_t  issue_packet [NC];

    rs_issue_select dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .entry_ready   (entry_ready),
        .entry_flag    (entry_flag),
        .entry_packet  (entry_packet),
        .cdb_packet_in (cdb_packet_in),
        .fu_ready      (fu_ready),
        .entry_clear   (entry_clear),
        .issue_valid   (issue_valid),
        .issue_packet  (issue_packet)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]             valid;
        is_packet_t [NC-1:0]    pkt;
    } exp_t;

    exp_t       sb [$];
    int         n_vec = 0;
    int         n_err = 0;

    logic       m_valid [NC];
    is_packet_t m_pkt   [NC];
    int         m_ptr   [NC];
    logic [7:0] clr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic is_packet_t mk(input logic [1:0] ch, input logic [31:0] a,
                                      input logic [31:0] b);
        is_packet_t p;
        p.valid      = 1'b1;
        p.channel    = ch;
        p.is_ZEROREG = 1'b0;
        p.opcode     = 6'h2A;
        p.rs1_value  = a;
        p.rs2_value  = b;
        return p;
    endfunction

    function automatic is_packet_t fwd(input is_packet_t p, input flag_e f, input logic [31:0] v);
        is_packet_t r;
        r = p;
        if (f == CDBTAG || f == CDBCDB) r.rs1_value = v;
        if (f == TAGCDB || f == CDBCDB) r.rs2_value = v;
        return r;
    endfunction

    task automatic clr_inputs();
        squash      = 1'b0;
        entry_ready = 8'h00;
        fu_ready    = 3'b111;
        cdb_packet_in = '{valid: 1'b0, tag: 5'd0, reg_value: 32'h0};
        for (int i = 0; i < RS; i++) begin
            entry_flag[i]   = TAGTAG;
            entry_packet[i] = mk(2'd0, 32'(i), 32'(i + 100));
        end
    endtask

    // One cycle: predict and check the clear now, check the issue registers after the edge.
    task automatic step(output logic [7:0] clr_o);
        exp_t       e;
        exp_t       got_e;
        logic [7:0] eclr;
        int         w;
        logic       free;
        #1;
        eclr = 8'h00;
        for (int c = 0; c < NC; c++) begin
            free = !m_valid[c] || fu_ready[c];
            w = -1;
            if (free && !squash && !reset) begin
                for (int k = 0; k < RS; k++) begin
                    int i;
                    i = (m_ptr[c] + k) % RS;
                    if (w < 0 && entry_ready[i] && int'(entry_packet[i].channel) == c) w = i;
                end
            end
            if (w >= 0) eclr[w] = 1'b1;
            if (reset) begin
                m_valid[c] = 1'b0; m_pkt[c] = NOP_PACKET; m_ptr[c] = 0;
            end else if (squash) begin
                m_valid[c] = 1'b0; m_pkt[c] = NOP_PACKET;
            end else if (w >= 0) begin
                m_valid[c] = 1'b1;
                m_pkt[c]   = fwd(entry_packet[w], entry_flag[w], cdb_packet_in.reg_value);
                m_ptr[c]   = (w + 1) % RS;
            end else if (fu_ready[c]) begin
                m_valid[c] = 1'b0;
            end
            e.valid[c] = m_valid[c];
            e.pkt[c]   = m_pkt[c];
        end
        clr_o = entry_clear;
        check("entry_clear", entry_clear, eclr);
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            got_e = sb.pop_front();
            check("issue_valid", issue_valid, got_e.valid);
            for (int c = 0; c < NC; c++) begin
                check($sformatf("issue_packet[%0d]", c), 128'(issue_packet[c]), 128'(got_e.pkt[c]));
            end
        end
        @(negedge clock);
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            m_valid[c] = 1'b0; m_pkt[c] = NOP_PACKET; m_ptr[c] = 0;
        end
        clr_inputs();
        reset = 1'b1;
        entry_ready = 8'hFF;
        @(negedge clock);

        // Reset with everything ready: no clears, nothing valid.
        for (int k = 0; k < 2; k++) begin
            step(clr);
            check("rst_clear", clr, 8'h00);
            check("rst_valid", issue_valid, 3'b000);
        end
        reset = 1'b0;
        entry_ready = 8'h00;
        step(clr);
        check("post_rst_valid", issue_valid, 3'b000);

        // Single ALU issue from entry 3.
        clr_inputs();
        entry_packet[3] = mk(2'd0, 32'd5, 32'd7);
        entry_ready = 8'h08;
        step(clr);
        check("s2_clear", clr, 8'h08);
        check("s2_valid", issue_valid[0], 1'b1);
        check("s2_rs1", issue_packet[0].rs1_value, 32'd5);
        check("s2_rs2", issue_packet[0].rs2_value, 32'd7);
        // Pointer now 4: entries 2 and 5 ready, 5 must win.
        entry_ready = 8'h24;
        step(clr);
        check("s2_ptr", clr, 8'h20);

        reset = 1'b1;
        entry_ready = 8'h00;
        step(clr);
        reset = 1'b0;

        // Round-robin alternation between entries 1 and 5.
        clr_inputs();
        entry_ready = 8'h22;
        step(clr);
        check("rr0_clear", clr, 8'h02);
        check("rr0_pkt", issue_packet[0].rs1_value, 32'd1);
        step(clr);
        check("rr1_clear", clr, 8'h20);
        check("rr1_pkt", issue_packet[0].rs1_value, 32'd5);
        step(clr);
        check("rr2_clear", clr, 8'h02);
        check("rr2_pkt", issue_packet[0].rs1_value, 32'd1);

        // CDB forwarding on MULT.
        clr_inputs();
        entry_packet[2] = mk(2'd1, 32'h11, 32'h22);
        entry_flag[2]   = CDBCDB;
        cdb_packet_in   = '{valid: 1'b1, tag: 5'd3, reg_value: 32'hDEADBEEF};
        entry_ready     = 8'h04;
        step(clr);
        check("cdbcdb_rs1", issue_packet[1].rs1_value, 32'hDEADBEEF);
        check("cdbcdb_rs2", issue_packet[1].rs2_value, 32'hDEADBEEF);
        entry_flag[2] = TAGCDB;
        step(clr);
        check("tagcdb_rs1", issue_packet[1].rs1_value, 32'h11);
        check("tagcdb_rs2", issue_packet[1].rs2_value, 32'hDEADBEEF);

        // MEM backpressure while ALU keeps issuing.
        clr_inputs();
        entry_packet[7] = mk(2'd2, 32'h77, 32'h78);
        entry_ready     = 8'h80;
        step(clr);
        entry_packet[6] = mk(2'd2, 32'h66, 32'h67);
        entry_ready     = 8'h41;
        fu_ready        = 3'b011;
        for (int k = 0; k < 3; k++) begin
            step(clr);
            check("bp_clear6", clr[6], 1'b0);
            check("bp_clear0", clr[0], 1'b1);
            check("bp_mem_hold", issue_packet[2].rs1_value, 32'h77);
        end
        fu_ready = 3'b111;
        step(clr);
        check("bp_release", clr, 8'h41);
        check("bp_mem_new", issue_packet[2].rs1_value, 32'h66);

        // Squash with a held ALU packet: clears suppressed, pointer kept at 2.
        clr_inputs();
        entry_ready = 8'h02;
        step(clr);
        squash      = 1'b1;
        fu_ready    = 3'b110;
        entry_ready = 8'h10;
        step(clr);
        check("sq_clear", clr, 8'h00);
        check("sq_valid", issue_valid[0], 1'b0);
        squash      = 1'b0;
        fu_ready    = 3'b111;
        entry_ready = 8'h12;
        step(clr);
        check("sq_ptr", clr, 8'h10);

        // Random traffic, including the unused channel code 3.
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < RS; i++) begin
                entry_packet[i] = mk(2'($urandom_range(0, 3)), $urandom, $urandom);
                entry_flag[i]   = flag_e'(2'($urandom_range(0, 3)));
            end
            entry_ready   = 8'($urandom);
            fu_ready      = 3'($urandom);
            squash        = ($urandom_range(0, 15) == 0);
            cdb_packet_in = '{valid: 1'b1, tag: 5'($urandom), reg_value: $urandom};
            step(clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue stage directly downstream of the reservation-station entry array.
- Each cycle, picks at most one ready entry per functional-unit channel using a per-channel round-robin pointer.
- Pulses that entry's clear line, resolves CDB-forwarded operands, and latches the result into a per-channel issue register.
- Each issue register is held under valid/ready backpressure until its functional unit accepts it.

Parameters:
- RS_SIZE, 8, number of reservation-station entries observed.
- NUM_CH, 3, number of FU channels (ALU, MULT, MEM); channel index equals the CHANNEL enum value.
- PTR_W, $clog2(RS_SIZE), width of each round-robin pointer.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  pipeline flush; synchronous, same priority as reset for issue registers.
- entry_ready  in  RS_SIZE  per-entry ready (busy and operands resolvable this cycle).
- entry_flag  in  RS_SIZE x FLAG  operand source per entry: TAGTAG, TAGCDB, CDBTAG, CDBCDB.
- entry_packet  in  RS_SIZE x IS_PACKET  per-entry latched packet; its channel field selects the FU.
- cdb_packet_in  in  CDB_PACKET  current broadcast; reg_value is used for forwarding.
- fu_ready  in  NUM_CH  FU accepts the issue register this cycle.
- entry_clear  out  RS_SIZE  combinational one-cycle clear to the winning entries; at most one bit per channel.
- issue_valid  out  NUM_CH  issue register holds a valid packet.
- issue_packet  out  NUM_CH x IS_PACKET  registered packet to each FU.

Behaviour:
- Reset (synchronous, active-high):
  - issue_valid = 0.
  - issue_packet = NOP packet: valid=0, is_ZEROREG=1, rs1_value=rs2_value=0.
  - All rr_ptr = 0.
  - entry_clear = 0 while reset is high.
- Per-channel state machine (2 states):
  - EMPTY: issue_valid=0.
  - FULL: issue_valid=1.
  - EMPTY -> FULL when a winner exists.
  - FULL -> EMPTY when fu_ready=1 and there is no winner.
  - FULL stays FULL (a new packet is loaded) when fu_ready=1 and a winner exists.
  - FULL with fu_ready=0 holds; packet is bit-stable.
- slot_free[c] = !issue_valid[c] || fu_ready[c].
- Candidate set for c = entries with entry_ready=1 and entry_packet.channel==c.
- Selection (combinational, same cycle):
  - Winner = first candidate at index ≥ rr_ptr[c], wrapping modulo RS_SIZE.
  - Considered only if slot_free[c] and !squash and !reset.
  - entry_clear[winner]=1 in that cycle only.
  - No winner, or slot not free: no clear for that channel.
- Latch (next edge):
  - issue_packet[c] = entry_packet[winner], with operand override:
    - TAGTAG: no change.
    - TAGCDB: rs2_value = cdb reg_value.
    - CDBTAG: rs1_value = cdb reg_value.
    - CDBCDB: both = cdb reg_value.
  - rr_ptr[c] = (winner+1) mod RS_SIZE; on wrap from RS_SIZE-1 the pointer becomes 0.
  - rr_ptr unchanged when nothing is issued.
- Latency: entry ready at cycle N -> entry_clear at N -> issue_valid/issue_packet at N+1.
- Backpressure:
  - A ready entry not selected keeps its busy/ready state and latches any CDB value itself.
  - Its flag in later cycles reflects that, so no value is lost.
- Simultaneous events:
  - Distinct channels are independent; up to NUM_CH clears per cycle.
  - An entry is never cleared by two channels, since channel is unique per entry.
- Squash:
  - issue_valid cleared next edge; entry_clear forced 0 in the squash cycle.
  - rr_ptr retained.
  - Squash mid-backpressure drops the held packet.
- A channel value ≥ NUM_CH is never selected.
- No combinational path from fu_ready to issue_packet. A combinational fu_ready -> entry_clear path is allowed.

Decomposition:
- Shared package (sys_defs): IS_PACKET, CDB_PACKET, FLAG enum (TAGTAG, TAGCDB, CDBTAG, CDBCDB), CHANNEL enum (ALU, MULT, MEM), NOP packet constant.
- Sub-module rr_picker:
  - Inputs: RS_SIZE-bit request vector, PTR_W pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Implemented by double-width masking; instantiated NUM_CH times.

Test Plan:
- Reset for 2 cycles with entry_ready=8'hFF -> entry_clear=0, issue_valid=0, all issue_packet.valid=0 during reset and the cycle after deassert.
- Entry 3 ready, channel ALU, flag TAGTAG, rs1=5, rs2=7, fu_ready=1 -> entry_clear=8'h08 at cycle 0; at cycle 1 issue_valid[ALU]=1, rs1=5, rs2=7; rr_ptr[ALU]=4.
- Entries 1 and 5 ready on ALU every cycle, rr_ptr=0, fu_ready=1 -> clears 8'h02, 8'h20, 8'h02 on successive cycles; issued packets alternate 1, 5, 1.
- Entry 2 on MULT with flag CDBCDB, cdb reg_value=32'hDEADBEEF -> issued MULT packet rs1_value=rs2_value=32'hDEADBEEF; with flag TAGCDB only rs2 is replaced.
- issue_valid[MEM]=1, fu_ready[MEM]=0 for 3 cycles, entry 6 ready on MEM -> entry_clear[6]=0 and MEM packet unchanged for 3 cycles. Meanwhile ALU entry 0 issues normally. On fu_ready[MEM]=1, clear[6] pulses and entry 6 is loaded next cycle.
- issue_valid[ALU]=1 with squash asserted while entry 4 is ready -> entry_clear=0 that cycle; next cycle issue_valid=0 and rr_ptr is unchanged.
